// File: rtl/boost_pkg.sv
// Shared definitions for the charge/fire sequencer: FSM state codes,
// register offsets, CTRL/STATUS bit positions and small helpers.
package boost_pkg;

    // State codes are visible to firmware through STATUS[7:4].
    typedef enum logic [3:0] {
        ST_INIT     = 4'd0,
        ST_IDLE     = 4'd1,
        ST_CHARGE   = 4'd2,
        ST_SETTLE   = 4'd3,
        ST_FIRE     = 4'd4,
        ST_COOLDOWN = 4'd5,
        ST_FAULT    = 4'd6
    } state_e;

    // Register offsets from the base address.
    localparam logic [4:0] OFS_CTRL   = 5'h00;
    localparam logic [4:0] OFS_STATUS = 5'h04;
    localparam logic [4:0] OFS_TARGET = 5'h08;
    localparam logic [4:0] OFS_WIDTH  = 5'h0C;
    localparam logic [4:0] OFS_SHOTS  = 5'h10;

    // CTRL pulse bits.
    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;
    localparam int CTRL_CLEAR = 2;

    // STATUS bit positions.
    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_TIMEOUT   = 2;
    localparam int STAT_SAG       = 3;
    localparam int STAT_STATE_LSB = 4;

    localparam int TIMER_W = 24;

    // Drive outputs toward the boost controller and the coil.
    typedef struct packed {
        logic init;
        logic enable;
        logic fire;
    } drive_t;

    // Outputs that belong to each state; at most one bit is ever set.
    function automatic drive_t drive_for(input state_e s);
        drive_t d;
        d = '0;
        case (s)
            ST_INIT:   d.init   = 1'b1;
            ST_CHARGE: d.enable = 1'b1;
            ST_FIRE:   d.fire   = 1'b1;
            default:   d = '0;
        endcase
        return d;
    endfunction

    // a - b clamped at zero, for the sag threshold.
    function automatic logic [11:0] sat_sub12(input logic [11:0] a, input logic [11:0] b);
        return (a > b) ? (a - b) : 12'd0;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Shared state timer: cleared by a load pulse on the first cycle of a
// state, then counts up; expired flags that the elapsed count hit limit.
module cycle_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] elapsed;

    // During the load cycle the stale count is hidden so the first cycle of
    // a state reads as zero elapsed.
    assign elapsed = load ? '0 : cnt_q;
    assign expired = (elapsed == limit);

    // Count cycles since state entry, saturating at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= {{(W-1){1'b0}}, 1'b1};
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/charge_fire_sequencer.sv
// Memory-mapped shot sequencer: calibrates the boost converter, charges to
// a target voltage, lets it settle, fires the coil and enforces a cooldown.
module charge_fire_sequencer
    import boost_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0100,
    parameter int unsigned CHARGE_TIMEOUT = 2000000,
    parameter int unsigned SETTLE_TIME    = 5000,
    parameter int unsigned VOUT_MARGIN    = 20,
    parameter int unsigned COOLDOWN_TIME  = 100000,
    parameter logic [15:0] FIRE_WIDTH_RST = 16'd1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid_i,
    output logic        mem_ready_o,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic [31:0] mem_rdata_o,
    input  logic [11:0] vout_adc,
    input  logic        boost_running,
    input  logic        boost_init_finished,
    output logic        boost_init_o,
    output logic        boost_enable_o,
    output logic        fire_out
);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [31:0] addr_diff;
    logic [4:0]  ofs;
    logic        addressed;
    logic        addr_seen_q;
    logic        first;
    logic        wr_hit;
    logic        rd_hit;
    logic        ctrl_wr;
    logic        start_p;
    logic        abort_p;
    logic        clear_p;
    logic [31:0] rd_mux;

    // Register file
    logic [11:0] target_q;
    logic [15:0] width_q;
    logic [11:0] vout_q;

    // FSM state
    state_e      state_q;
    drive_t      drive_q;
    logic        entry_q;
    logic        done_q;
    logic        timeout_q;
    logic        sag_q;
    logic [15:0] width_lat_q;
    logic [15:0] shot_count_q;

    // Timer interface
    logic [TIMER_W-1:0] tmr_limit;
    logic               tmr_expired;

    logic        busy;
    logic [11:0] sag_floor;
    logic [15:0] eff_width;

    assign addr_diff = mem_addr_i - BASE_ADDR;
    assign ofs       = addr_diff[4:0];
    assign addressed = mem_valid_i && (mem_addr_i >= BASE_ADDR) && (addr_diff <= 32'h10);

    // A transaction is acted on only in the cycle it is first seen, so a
    // master holding valid gets exactly one ack.
    assign first   = addressed && !addr_seen_q;
    assign wr_hit  = first && (|mem_wstrb_i);
    assign rd_hit  = first && !(|mem_wstrb_i);
    assign ctrl_wr = wr_hit && (ofs == OFS_CTRL);

    // fault_clear outranks abort, which outranks start; a start sharing a
    // write with either of the others is dropped.
    assign clear_p = ctrl_wr && mem_wdata_i[CTRL_CLEAR];
    assign abort_p = ctrl_wr && mem_wdata_i[CTRL_ABORT] && !mem_wdata_i[CTRL_CLEAR];
    assign start_p = ctrl_wr && mem_wdata_i[CTRL_START]
                     && !mem_wdata_i[CTRL_ABORT] && !mem_wdata_i[CTRL_CLEAR];

    assign busy      = !((state_q == ST_IDLE) || (state_q == ST_FAULT));
    assign sag_floor = sat_sub12(target_q, 12'(VOUT_MARGIN));
    assign eff_width = (width_q == 16'd0) ? 16'd1 : width_q;

    // Read data selection for mapped offsets; everything else reads zero.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        rd_mux = '0;
        case (ofs)
            OFS_STATUS: begin
                rd_mux[STAT_BUSY]                       = busy;
                rd_mux[STAT_DONE]                       = done_q;
                rd_mux[STAT_TIMEOUT]                    = timeout_q;
                rd_mux[STAT_SAG]                        = sag_q;
                rd_mux[STAT_STATE_LSB+3:STAT_STATE_LSB] = state_q;
            end
            OFS_TARGET: rd_mux[11:0] = target_q;
            OFS_WIDTH:  rd_mux[15:0] = width_q;
            OFS_SHOTS:  rd_mux[15:0] = shot_count_q;
            default:    rd_mux = '0;
        endcase
    end

    // Bus handshake, read data register and the two RW configuration registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_seen_q <= 1'b0;
            mem_ready_o <= 1'b0;
            mem_rdata_o <= '0;
            target_q    <= '0;
            width_q     <= FIRE_WIDTH_RST;
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
            addr_seen_q <= addressed;
            mem_ready_o <= first;
            mem_rdata_o <= rd_hit ? rd_mux : '0;
            if (wr_hit && (ofs == OFS_TARGET)) begin
                target_q <= mem_wdata_i[11:0];
            end
            if (wr_hit && (ofs == OFS_WIDTH)) begin
                width_q <= mem_wdata_i[15:0];
            end
        end
    end

    // Single sampling point for the ADC so all compares see one value per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vout_q <= '0;
        end else begin
            vout_q <= vout_adc;
        end
    end

    // Per-state timer limit; the timer reads zero on the first cycle of a
    // state, so a limit of N-1 gives a state that lasts N cycles.
    always_comb begin
        tmr_limit = '0;
        case (state_q)
            ST_CHARGE:   tmr_limit = TIMER_W'(CHARGE_TIMEOUT);
            ST_SETTLE:   tmr_limit = TIMER_W'(SETTLE_TIME - 1);
            ST_FIRE:     tmr_limit = {8'd0, width_lat_q} - 24'd1;
            ST_COOLDOWN: tmr_limit = TIMER_W'(COOLDOWN_TIME - 1);
            default:     tmr_limit = '0;
        endcase
    end

    cycle_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (entry_q),
        .limit   (tmr_limit),
        .expired (tmr_expired)
    );

    // Shot sequencer with registered drive outputs, sticky flags and shot counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_INIT;
            drive_q      <= '0;
            entry_q      <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            sag_q        <= 1'b0;
            width_lat_q  <= 16'd1;
            shot_count_q <= '0;
        end else begin
            // Hold the current state's outputs unless a transition below overrides them.
            drive_q <= drive_for(state_q);
            entry_q <= 1'b0;
            if (abort_p && (state_q inside {ST_CHARGE, ST_SETTLE, ST_FIRE, ST_COOLDOWN})) begin
                state_q <= ST_IDLE;
                drive_q <= '0;
                entry_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_INIT: begin
                        if (boost_init_finished) begin
                            state_q <= ST_IDLE;
                            drive_q <= drive_for(ST_IDLE);
                            entry_q <= 1'b1;
                        end
                    end
                    ST_IDLE: begin
                        if (start_p && (target_q != 12'd0)) begin
                            state_q <= ST_CHARGE;
                            drive_q <= drive_for(ST_CHARGE);
                            entry_q <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                    ST_CHARGE: begin
                        if ((vout_q >= target_q) && !boost_running) begin
                            state_q <= ST_SETTLE;
                            drive_q <= drive_for(ST_SETTLE);
                            entry_q <= 1'b1;
                        end else if (tmr_expired) begin
                            state_q   <= ST_FAULT;
                            drive_q   <= drive_for(ST_FAULT);
                            entry_q   <= 1'b1;
                            timeout_q <= 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (tmr_expired) begin
                            if (vout_q >= sag_floor) begin
                                state_q     <= ST_FIRE;
                                drive_q     <= drive_for(ST_FIRE);
                                entry_q     <= 1'b1;
                                width_lat_q <= eff_width;
                            end else begin
                                state_q <= ST_FAULT;
                                drive_q <= drive_for(ST_FAULT);
                                entry_q <= 1'b1;
                                sag_q   <= 1'b1;
                            end
                        end
                    end
                    ST_FIRE: begin
                        if (tmr_expired) begin
                            state_q      <= ST_COOLDOWN;
                            drive_q      <= drive_for(ST_COOLDOWN);
                            entry_q      <= 1'b1;
                            shot_count_q <= shot_count_q + 16'd1;
                        end
                    end
                    ST_COOLDOWN: begin
                        if (tmr_expired) begin
                            state_q <= ST_IDLE;
                            drive_q <= drive_for(ST_IDLE);
                            entry_q <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end
                    ST_FAULT: begin
                        if (clear_p) begin
                            state_q   <= ST_IDLE;
                            drive_q   <= drive_for(ST_IDLE);
                            entry_q   <= 1'b1;
                            timeout_q <= 1'b0;
                            sag_q     <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_INIT;
                        drive_q <= '0;
                        entry_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign boost_init_o   = drive_q.init;
    assign boost_enable_o = drive_q.enable;
    assign fire_out       = drive_q.fire;

    // Bus bits that carry no register content.
    logic unused_bits;
    assign unused_bits = &{1'b0, addr_diff[31:5], mem_wdata_i[31:16]};

endmodule

// File: tb/tb_charge_fire_sequencer.sv
// Directed bench for charge_fire_sequencer with shortened timing parameters.
module tb_charge_fire_sequencer;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int CT = 300;
    localparam int ST = 40;
    localparam int CD = 60;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_valid_i = 1'b0;
    logic        mem_ready_o;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [3:0]  mem_wstrb_i = '0;
    logic [31:0] mem_rdata_o;
    logic [11:0] vout_adc = '0;
    logic        boost_running = 1'b0;
    logic        boost_init_finished = 1'b0;
    logic        boost_init_o;
    logic        boost_enable_o;
    logic        fire_out;

    charge_fire_sequencer #(
        .BASE_ADDR      (BASE),
        .CHARGE_TIMEOUT (CT),
        .SETTLE_TIME    (ST),
        .VOUT_MARGIN    (20),
        .COOLDOWN_TIME  (CD),
        .FIRE_WIDTH_RST (16'd1000)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .mem_valid_i         (mem_valid_i),
        .mem_ready_o         (mem_ready_o),
        .mem_addr_i          (mem_addr_i),
        .mem_wdata_i         (mem_wdata_i),
        .mem_wstrb_i         (mem_wstrb_i),
        .mem_rdata_o         (mem_rdata_o),
        .vout_adc            (vout_adc),
        .boost_running       (boost_running),
        .boost_init_finished (boost_init_finished),
        .boost_init_o        (boost_init_o),
        .boost_enable_o      (boost_enable_o),
        .fire_out            (fire_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fire_cnt = 0;
    int en_cnt = 0;
    int overlap = 0;

    // Cycle-level monitors; at the posedge these see the values of the cycle just ending.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fire_out) fire_cnt <= fire_cnt + 1;
        if (boost_enable_o) en_cnt <= en_cnt + 1;
        if ($countones({boost_init_o, boost_enable_o, fire_out}) > 1) overlap <= overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] st_word(input logic [3:0] s, input logic done,
                                            input logic tmo, input logic sag);
        logic busy;
        busy = !((s == 4'd1) || (s == 4'd6));
        return {24'd0, s, sag, tmo, done, busy};
    endfunction

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        logic got;
        got = 1'b0;
        @(negedge clk);
        mem_valid_i = 1'b1;
        mem_addr_i  = addr;
        mem_wdata_i = data;
        mem_wstrb_i = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready_o) begin
                got = 1'b1;
                break;
            end
        end
        check("wr_ack", {31'd0, got}, 32'd1);
        @(negedge clk);
        mem_valid_i = 1'b0;
        mem_wstrb_i = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        logic got;
        got  = 1'b0;
        data = '0;
        @(negedge clk);
        mem_valid_i = 1'b1;
        mem_addr_i  = addr;
        mem_wstrb_i = 4'h0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready_o) begin
                got  = 1'b1;
                data = mem_rdata_o;
                break;
            end
        end
        check("rd_ack", {31'd0, got}, 32'd1);
        @(negedge clk);
        mem_valid_i = 1'b0;
    endtask

    task automatic wait_fire(input logic lvl, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fire_out === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Start a shot and bring vout to the 0x800 target with the converter idle.
    task automatic start_and_reach;
        vout_adc      = 12'h100;
        boost_running = 1'b1;
        bus_write(BASE, 32'h1);
        @(negedge clk);
        vout_adc      = 12'h800;
        boost_running = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        ok;
        int          init_hi;
        int          c0;
        int          f0;
        int          e0;
        int          rdy;
        logic [31:0] cap;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_outs", {28'd0, boost_init_o, boost_enable_o, fire_out, mem_ready_o}, 32'd0);
        check("rst_rdata", mem_rdata_o, 32'd0);
        reset = 1'b1;

        // Calibration: init high cycles 1..10, finished arrives at cycle 10.
        init_hi = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (boost_init_o) init_hi++;
            if (i == 10) boost_init_finished = 1'b1;
        end
        @(negedge clk);
        check("init_cycles", init_hi, 10);
        check("init_drop", {31'd0, boost_init_o}, 32'd0);
        bus_read(BASE + 32'h4, d);
        check("idle_status", d, st_word(4'd1, 1'b0, 1'b0, 1'b0));
        bus_read(BASE + 32'h8, d);
        check("target_rst", d, 32'd0);
        bus_read(BASE + 32'hC, d);
        check("width_rst", d, 32'd1000);

        // Normal shot, width 50.
        bus_write(BASE + 32'h8, 32'h800);
        bus_write(BASE + 32'hC, 32'd50);
        vout_adc      = 12'h100;
        boost_running = 1'b1;
        bus_write(BASE, 32'h1);
        bus_read(BASE + 32'h4, d);
        check("chg_status", d, st_word(4'd2, 1'b0, 1'b0, 1'b0));
        check("chg_enable", {31'd0, boost_enable_o}, 32'd1);
        @(negedge clk);
        vout_adc      = 12'h800;
        boost_running = 1'b0;
        c0 = cyc;
        wait_fire(1'b1, ST + 20, ok);
        check("fire_seen", {31'd0, ok}, 32'd1);
        // One cycle to register vout, one for the CHARGE decision, then SETTLE_TIME.
        check("fire_delay", cyc - c0, ST + 2);
        f0 = fire_cnt;
        bus_write(BASE + 32'hC, 32'd7);
        wait_fire(1'b0, 100, ok);
        check("fire_fell", {31'd0, ok}, 32'd1);
        check("fire_width", fire_cnt - f0, 50);
        bus_read(BASE + 32'h10, d);
        check("shot1", d, 32'd1);
        bus_read(BASE + 32'h4, d);
        check("cool_status", d, st_word(4'd5, 1'b0, 1'b0, 1'b0));
        repeat (CD + 10) @(negedge clk);
        bus_read(BASE + 32'h4, d);
        check("done_status", d, st_word(4'd1, 1'b1, 1'b0, 1'b0));

        // Charge timeout.
        vout_adc      = 12'h100;
        boost_running = 1'b1;
        e0 = en_cnt;
        bus_write(BASE, 32'h1);
        ok = 1'b0;
        for (int i = 0; i < CT + 50; i++) begin
            @(negedge clk);
            if (!boost_enable_o) begin
                ok = 1'b1;
                break;
            end
        end
        check("tmo_seen", {31'd0, ok}, 32'd1);
        check("tmo_len", {31'd0, ((en_cnt - e0) >= CT) && ((en_cnt - e0) <= CT + 1)}, 32'd1);
        bus_read(BASE + 32'h4, d);
        check("tmo_status", d, st_word(4'd6, 1'b0, 1'b1, 1'b0));
        bus_write(BASE, 32'h1);
        bus_read(BASE + 32'h4, d);
        check("fault_start_ign", d, st_word(4'd6, 1'b0, 1'b1, 1'b0));
        bus_write(BASE, 32'h4);
        bus_read(BASE + 32'h4, d);
        check("fault_clear", d, st_word(4'd1, 1'b0, 1'b0, 1'b0));

        // Sag one LSB below the margin during SETTLE.
        f0 = fire_cnt;
        start_and_reach();
        repeat (5) @(negedge clk);
        vout_adc = 12'h800 - 12'd21;
        repeat (ST + 10) @(negedge clk);
        bus_read(BASE + 32'h4, d);
        check("sag_status", d, st_word(4'd6, 1'b0, 1'b0, 1'b1));
        check("sag_nofire", fire_cnt - f0, 0);
        bus_write(BASE, 32'h4);

        // Sag exactly at the margin still fires; width 0 behaves as 1.
        bus_write(BASE + 32'hC, 32'd0);
        f0 = fire_cnt;
        start_and_reach();
        repeat (5) @(negedge clk);
        vout_adc = 12'h800 - 12'd20;
        wait_fire(1'b1, ST + 20, ok);
        check("edge_fire_seen", {31'd0, ok}, 32'd1);
        wait_fire(1'b0, 20, ok);
        check("w0_width", fire_cnt - f0, 1);
        repeat (CD + 10) @(negedge clk);
        bus_read(BASE + 32'h10, d);
        check("shot2", d, 32'd2);
        vout_adc = 12'h800;

        // Abort 20 cycles into a 100-cycle fire.
        bus_write(BASE + 32'hC, 32'd100);
        start_and_reach();
        wait_fire(1'b1, ST + 20, ok);
        check("abort_fire_seen", {31'd0, ok}, 32'd1);
        f0 = fire_cnt;
        repeat (19) @(negedge clk);
        bus_write(BASE, 32'h2);
        check("abort_fire_low", {31'd0, fire_out}, 32'd0);
        check("abort_len", fire_cnt - f0, 21);
        bus_read(BASE + 32'h4, d);
        check("abort_status", d, st_word(4'd1, 1'b0, 1'b0, 1'b0));
        bus_read(BASE + 32'h10, d);
        check("abort_shots", d, 32'd2);
        bus_write(BASE, 32'h3);
        bus_read(BASE + 32'h4, d);
        check("ctrl3_idle", d, st_word(4'd1, 1'b0, 1'b0, 1'b0));
        check("ctrl3_noen", {31'd0, boost_enable_o}, 32'd0);

        // Held request gives exactly one ack.
        @(negedge clk);
        mem_valid_i = 1'b1;
        mem_addr_i  = BASE + 32'h10;
        mem_wstrb_i = 4'h0;
        rdy = 0;
        cap = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready_o) begin
                rdy++;
                cap = mem_rdata_o;
            end
        end
        @(negedge clk);
        mem_valid_i = 1'b0;
        check("hold_one_ack", rdy, 1);
        check("hold_data", cap, 32'd2);

        // 0x14 lies outside the window: no ack, data stays zero.
        @(negedge clk);
        mem_valid_i = 1'b1;
        mem_addr_i  = BASE + 32'h14;
        rdy = 0;
        cap = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready_o) rdy++;
            cap = cap | mem_rdata_o;
        end
        @(negedge clk);
        mem_valid_i = 1'b0;
        check("oow_no_ack", rdy, 0);
        check("oow_data", cap, 32'd0);

        bus_read(BASE + 32'h2, d);
        check("unmapped_rd", d, 32'd0);
        bus_read(BASE, d);
        check("ctrl_reads0", d, 32'd0);
        bus_write(BASE + 32'h4, 32'hFF);
        bus_read(BASE + 32'h4, d);
        check("status_ro", d, st_word(4'd1, 1'b0, 1'b0, 1'b0));

        // SHOT_COUNT wrap.
        force dut.shot_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.shot_count_q;
        bus_read(BASE + 32'h10, d);
        check("shots_preset", d, 32'hFFFF);
        start_and_reach();
        wait_fire(1'b1, ST + 20, ok);
        check("wrap_fire_seen", {31'd0, ok}, 32'd1);
        wait_fire(1'b0, 200, ok);
        check("wrap_fire_fell", {31'd0, ok}, 32'd1);
        bus_read(BASE + 32'h10, d);
        check("shots_wrap", d, 32'd0);

        check("exclusive", overlap, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
